// File: rtl/simon_pkg.sv
// Shared Simon-game constants: colour codes, the button read address and the
// layout of the word returned on a button poll.
package simon_pkg;

    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_BLUE   = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    localparam logic [11:0] ADDR_BUTTON = 12'd7;

    localparam int VALID_BIT = 0;
    localparam int COLOR_LSB = 1;
    localparam int OVF_BIT   = 3;

    function automatic logic [31:0] pack_read(input logic       valid,
                                              input logic [1:0] color,
                                              input logic       ovf);
        logic [31:0] r_word;
        r_word                  = '0;
        r_word[VALID_BIT]       = valid;
        r_word[COLOR_LSB +: 2]  = color;
        r_word[OVF_BIT]         = ovf;
        return r_word;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button; emits the
// accepted level and a one-cycle pulse on the cycle the level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_rise;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // Level held long enough: accept it; only a rising change is an event
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_rise   <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule

// File: rtl/button_event_queue.sv
// Simon button responder: debounces four buttons, queues colour press events
// and returns the oldest one to the processor on a poll of the button address.
module button_event_queue
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          red_button,
    input  logic                          blue_button,
    input  logic                          green_button,
    input  logic                          yellow_button,
    input  logic                          poll,
    output logic [31:0]                   data_out,
    output logic [$clog2(FIFO_DEPTH):0]   event_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [3:0]    w_raw;
    logic [3:0]    w_stable;
    logic [3:0]    w_rise;
    logic [3:0]    w_press;
    logic [3:0]    w_req;
    logic [3:0]    w_grant;
    logic [1:0]    w_push_color;
    logic          w_push_req;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [1:0]    w_head;

    logic [3:0]    r_pending;
    logic [1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic          r_overflow;
    logic          r_poll_q;

    // Index order is also the arbitration priority and the colour code
    assign w_raw = {yellow_button, green_button, blue_button, red_button};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .i_clock (clock),
            .i_reset (reset),
            .i_button(w_raw[g]),
            .o_stable(w_stable[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_press    = w_rise & w_stable;
    assign w_req      = r_pending | w_press;
    assign w_push_req = |w_req;

    always_comb begin
        w_grant      = '0;
        w_push_color = COLOR_RED;
        if (w_req[0]) begin
            w_grant      = 4'b0001;
            w_push_color = COLOR_RED;
        end else if (w_req[1]) begin
            w_grant      = 4'b0010;
            w_push_color = COLOR_BLUE;
        end else if (w_req[2]) begin
            w_grant      = 4'b0100;
            w_push_color = COLOR_GREEN;
        end else if (w_req[3]) begin
            w_grant      = 4'b1000;
            w_push_color = COLOR_YELLOW;
        end
    end

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = poll & ~r_poll_q & ~w_empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
            r_poll_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_poll_q  <= poll;
            r_pending <= w_req & ~w_grant;
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= w_push_color;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_pop) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head      = w_empty ? COLOR_RED : r_mem[r_rd[AW-1:0]];
    assign data_out    = pack_read(~w_empty, w_head, r_overflow);
    assign event_count = r_wr - r_rd;

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue: directed scenarios plus random button/poll
// traffic, compared every cycle against a queue-based behavioural model.
module tb_button_event_queue;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  btns;
    logic        poll;
    logic [31:0] data_out;
    logic [2:0]  event_count;

    int n_checks;
    int n_fail;

    button_event_queue #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .red_button   (btns[0]),
        .blue_button  (btns[1]),
        .green_button (btns[2]),
        .yellow_button(btns[3]),
        .poll         (poll),
        .data_out     (data_out),
        .event_count  (event_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: per-button delayed samples and run length of disagreement,
    // event queue as a plain SV queue of colour indices
    bit m_s1 [4];
    bit m_s2 [4];
    bit m_st [4];
    bit m_rise [4];
    bit m_pend [4];
    int m_run [4];
    int m_q [$];
    bit m_ovf;
    bit m_pollq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0;
            m_rise[i] = 0; m_pend[i] = 0; m_run[i] = 0;
        end
        m_q.delete();
        m_ovf   = 0;
        m_pollq = 0;
    endtask

    task automatic model_step();
        bit req [4];
        int gi;
        bit pop;
        gi = -1;
        for (int i = 0; i < 4; i++) begin
            req[i] = m_pend[i] | m_rise[i];
            if (gi < 0 && req[i]) gi = i;
        end
        pop = poll && !m_pollq && (m_q.size() > 0);
        if (pop) begin
            void'(m_q.pop_front());
            m_ovf = 0;
        end
        if (gi >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(gi);
            else m_ovf = 1;
            req[gi] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = req[i];
            m_rise[i] = 0;
            if (m_s2[i] != m_st[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_st[i]   = m_s2[i];
                    m_run[i]  = 0;
                    m_rise[i] = m_st[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btns[i];
        end
        m_pollq = poll;
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] v;
        v    = '0;
        v[3] = m_ovf;
        if (m_q.size() > 0) begin
            v[0]   = 1'b1;
            v[2:1] = 2'(m_q[0]);
        end
        return v;
    endfunction

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            if (!reset) model_step();
            @(negedge clock);
            chk("data", data_out, model_data());
            chk("count", {29'b0, event_count}, m_q.size());
        end
    endtask

    task automatic press(input int b);
        btns[b] = 1'b1;
        cyc(8);
        btns[b] = 1'b0;
        cyc(8);
    endtask

    task automatic poll_once();
        poll = 1'b1;
        cyc(1);
        poll = 1'b0;
        cyc(1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        btns     = '0;
        poll     = 1'b0;
        reset    = 1'b1;
        model_reset();
        cyc(3);
        reset = 1'b0;
        chk("rst_data", data_out, 32'h0);
        chk("rst_count", {29'b0, event_count}, 32'd0);

        // 1: single blue press
        btns[1] = 1'b1;
        cyc(6);
        chk("t1_cnt_before", {29'b0, event_count}, 32'd0);
        cyc(1);
        chk("t1_cnt_at7", {29'b0, event_count}, 32'd1);
        cyc(13);
        btns[1] = 1'b0;
        cyc(8);
        poll = 1'b1;
        #1 chk("t1_data", data_out, 32'h3);
        cyc(1);
        poll = 1'b0;
        chk("t1_cnt_after", {29'b0, event_count}, 32'd0);
        cyc(2);

        // 2: bouncing red never accepted
        for (int k = 0; k < 6; k++) begin
            btns[0] = ~btns[0];
            cyc(2);
        end
        btns[0] = 1'b0;
        cyc(8);
        chk("t2_count", {29'b0, event_count}, 32'd0);
        chk("t2_data", data_out, 32'h0);

        // 3: red and yellow together
        btns[0] = 1'b1;
        btns[3] = 1'b1;
        cyc(8);
        chk("t3_count", {29'b0, event_count}, 32'd2);
        cyc(4);
        btns = '0;
        cyc(8);
        chk("t3_first", data_out, 32'h1);
        poll_once();
        chk("t3_second", data_out, 32'h7);
        poll_once();
        chk("t3_empty", {29'b0, event_count}, 32'd0);

        // 4: overflow with five green presses
        for (int k = 0; k < 5; k++) press(2);
        chk("t4_count", {29'b0, event_count}, 32'd4);
        chk("t4_first", data_out, 32'hD);
        poll_once();
        chk("t4_second", data_out, 32'h5);
        poll_once();
        chk("t4_left", {29'b0, event_count}, 32'd2);

        // 5: long poll pops once, empty pop ignored
        poll = 1'b1;
        cyc(10);
        poll = 1'b0;
        chk("t5_long", {29'b0, event_count}, 32'd1);
        cyc(1);
        poll_once();
        chk("t5_drained", {29'b0, event_count}, 32'd0);
        poll = 1'b1;
        #1 chk("t5_empty_data", data_out, 32'h0);
        cyc(3);
        chk("t5_empty_cnt", {29'b0, event_count}, 32'd0);
        poll = 1'b0;
        cyc(1);

        // 6: reset with entries queued and yellow held
        for (int k = 0; k < 3; k++) press(1);
        chk("t6_queued", {29'b0, event_count}, 32'd3);
        btns[3] = 1'b1;
        cyc(3);
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_data", data_out, 32'h0);
        chk("t6_rst_cnt", {29'b0, event_count}, 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(7);
        chk("t6_yellow_cnt", {29'b0, event_count}, 32'd1);
        chk("t6_yellow_data", data_out, 32'h7);
        btns[3] = 1'b0;
        cyc(8);

        // Random traffic
        for (int it = 0; it < 1500; it++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) btns[b] = ~btns[b];
            end
            poll = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                model_reset();
                cyc(1);
                reset = 1'b0;
            end
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
